pipe_reg_if_id_hs: RTL and testbench
====================================

# pipe_reg_if_id_hs

Parametrised IF/ID pipeline register with a valid/ready handshake, a two-entry skid buffer, and synchronous flush. It sits between the fetch stage (PC adder plus instruction memory) and the decode stage. It carries the incremented PC and the fetched instruction. Back-pressure from decode stalls fetch without losing a beat, and a branch/jump flush turns the stage into a NOP bubble. The empty-stage value and data widths are parameters.

## Interface
- `B`, 32, instruction width in bits.
- `PC_W`, 32, incremented-PC width in bits.
- `NOP_INSTR`, `32'h00000000`, instruction word presented while the stage is empty. Width `B`; the default is MIPS `sll $0,$0,0`.
- `CNT_W`, 16, width of the flush-drop counter.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, reset, synchronous and active-low.
- `flush`, input, 1, synchronous and active-high; discards all stage contents.
- `in_valid`, input, 1, fetch presents a beat.
- `in_ready`, output, 1, stage can accept a beat this cycle.
- `pc_incrementado_in`, input, `PC_W`, incremented PC from fetch.
- `instruction_in`, input, `B`, fetched instruction.
- `out_valid`, output, 1, the head beat is valid.
- `out_ready`, input, 1, decode consumes the head this cycle.
- `pc_incrementado_out`, output, `PC_W`, head PC; all zeros when empty.
- `instruction_out`, output, `B`, head instruction; `NOP_INSTR` when empty.
- `occupancy`, output, 2, number of stored beats (0..2).
- `flush_drops`, output, `CNT_W`, saturating count of valid beats discarded by flush.

## Operation
- Storage is a head entry plus a skid entry, each holding {pc, instr}.
  - `count` is in {0,1,2}.
  - `occupancy` equals `count`.
- Combinational outputs from registered state:
  - `out_valid` = (`count` != 0).
  - `in_ready` = (`count` != 2).
- A push happens when `in_valid & in_ready`. A pop happens when `out_valid & out_ready`. Both are evaluated on pre-edge state.
- Data outputs:
  - When `count` = 0: pc = 0 and instr = `NOP_INSTR`, regardless of stored contents.
  - Otherwise the outputs show the head entry.
- Next state when `flush` = 0:
  - Push only, `count` 0: the beat goes to head, count becomes 1.
  - Push only, `count` 1: the beat goes to skid, count becomes 2.
  - Pop only, `count` 2: skid moves to head, count becomes 1.
  - Pop only, `count` 1: count becomes 0.
  - Push and pop together, `count` 1: head is replaced by the new beat, count stays 1.
  - Push and pop together, `count` 2: cannot occur, because `in_ready` = 0.
  - Neither: state is held, i.e. a stall.
- Flush (`flush` = 1 and `rst_n` = 1) has priority over push and pop:
  - `count` becomes 0.
  - `flush_drops` increases by (`count` + push), saturating at all ones.
  - A beat accepted in the same cycle (`in_ready` was 1) is consumed from fetch and discarded.
  - A pop in the same cycle still completes from decode's view and is not counted as dropped. The increment is (`count` − pop + push).
- Reset (`rst_n` = 0 at an edge) overrides everything:
  - `count` = 0.
  - Both entries are cleared to {0, `NOP_INSTR`}.
  - `flush_drops` = 0.
  - Reset in the middle of operation discards contents without counting drops.

## Timing
- Reset values: `out_valid` 0, `in_ready` 1, `pc_incrementado_out` 0, `instruction_out` `NOP_INSTR`, `occupancy` 0, `flush_drops` 0.
- Latency: a beat pushed into an empty stage at edge N appears with `out_valid` = 1 right after edge N, for the cycle N→N+1.
- Throughput: with `out_ready` held at 1, one beat per cycle and `count` stays at 1 or less.
- `in_ready` falls only when `count` reaches 2. That takes two consecutive back-pressured pushes, so fetch may register its stall one cycle late without loss.
- `in_ready` has no combinational path from `out_ready`; both `in_ready` and `out_valid` depend only on registers.
- The head holds stable while `out_valid & !out_ready`, with no data change.
- After a flush edge, `out_valid` = 0 for at least one cycle and `instruction_out` = `NOP_INSTR`.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with `in_valid` = 1 → after release, `occupancy` 0, `instruction_out` `32'h00000000`, `pc_incrementado_out` 0, `in_ready` 1, `flush_drops` 0.
- **Streaming:** push pc 4, 8, 12 with instr `0x8C100000`, `0x20080001`, `0x00000000` and `out_ready` = 1 → each appears one cycle after its push, in order, with `occupancy` ≤ 1 throughout.
- **Back-pressure:** set `out_ready` = 0 and push pc 4 then pc 8 → `occupancy` 2 and `in_ready` 0; then set `out_ready` = 1 → outputs pc 4 then pc 8 on consecutive cycles, with no loss or duplication.
- **Flush:**
  - With `occupancy` 2 and a third beat pending (`in_ready` 0), pulse `flush` → `occupancy` 0, `flush_drops` 2, `instruction_out` = NOP.
  - Repeat with `occupancy` 1, a push accepted, and a pop in the same cycle → `flush_drops` 3.
- **Counter saturation:** with `CNT_W` = 2, perform flushes dropping 1, 2, then 2 beats → `flush_drops` reads 1, 3, 3.
- **Simultaneous push and pop:** with `occupancy` 1 holding pc 4, assert `in_valid` (pc 8) and `out_ready` together → pc 8 at the head next cycle and `occupancy` stays 1.

Source files
------------

// File: rtl/pipe_reg_if_id_hs.sv
// pipe_reg_if_id_hs: IF/ID pipeline register with valid/ready handshake, two-entry skid buffer and flush
module pipe_reg_if_id_hs #(
  parameter int B = 32,
  parameter int PC_W = 32,
  parameter logic [B-1:0] NOP_INSTR = 32'h00000000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  pc_incrementado_in,
  input  logic [B-1:0]     instruction_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  pc_incrementado_out,
  output logic [B-1:0]     instruction_out,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_drops
);
  logic [1:0] count_q, count_d;
  logic [PC_W-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic [B-1:0] head_ins_q, head_ins_d, skid_ins_q, skid_ins_d;
  logic [CNT_W-1:0] drops_q, drops_d;
  logic push, pop;
  logic [1:0] inc;
  logic [CNT_W:0] sum;
  assign out_valid = count_q != 2'd0;
  assign in_ready = count_q != 2'd2;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign occupancy = count_q;
  assign flush_drops = drops_q;
  assign pc_incrementado_out = out_valid ? head_pc_q : '0;
  assign instruction_out = out_valid ? head_ins_q : NOP_INSTR;
  // Beats lost to a flush: everything stored plus any beat taken this cycle, minus one popped to decode.
  assign inc = count_q + {1'b0, push} - {1'b0, pop};
  assign sum = {1'b0, drops_q} + (CNT_W+1)'(inc);
  // Next state: flush wins over push/pop; a lone push fills head first, then skid; a pop promotes skid.
  always_comb begin
    count_d = count_q;
    head_pc_d = head_pc_q;
    head_ins_d = head_ins_q;
    skid_pc_d = skid_pc_q;
    skid_ins_d = skid_ins_q;
    drops_d = drops_q;
    if (flush) begin
      count_d = 2'd0;
      drops_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end else if (push && (pop || count_q == 2'd0)) begin
      head_pc_d = pc_incrementado_in;
      head_ins_d = instruction_in;
      count_d = 2'd1;
    end else if (push) begin
      skid_pc_d = pc_incrementado_in;
      skid_ins_d = instruction_in;
      count_d = 2'd2;
    end else if (pop) begin
      head_pc_d = skid_pc_q;
      head_ins_d = skid_ins_q;
      count_d = count_q - 2'd1;
    end
  end
  // State registers with synchronous active-low reset that clears contents without counting drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_pc_q <= '0;
      head_ins_q <= NOP_INSTR;
      skid_pc_q <= '0;
      skid_ins_q <= NOP_INSTR;
      drops_q <= '0;
    end else begin
      count_q <= count_d;
      head_pc_q <= head_pc_d;
      head_ins_q <= head_ins_d;
      skid_pc_q <= skid_pc_d;
      skid_ins_q <= skid_ins_d;
      drops_q <= drops_d;
    end
  end
endmodule

// File: tb/tb_pipe_reg_if_id_hs.sv
// tb_pipe_reg_if_id_hs: directed self-checking bench for pipe_reg_if_id_hs
module tb_pipe_reg_if_id_hs;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic flush2, in_valid2, out_ready2;
  logic [31:0] pc_in, ins_in;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] pc_out, ins_out, pc_out2, ins_out2;
  logic [1:0] occ, occ2;
  logic [15:0] drops;
  logic [1:0] drops2;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipe_reg_if_id_hs u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_incrementado_in(pc_in), .instruction_in(ins_in), .out_valid(out_valid), .out_ready(out_ready),
    .pc_incrementado_out(pc_out), .instruction_out(ins_out), .occupancy(occ), .flush_drops(drops)
  );
  pipe_reg_if_id_hs #(.CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .pc_incrementado_in(pc_in), .instruction_in(ins_in), .out_valid(out_valid2), .out_ready(out_ready2),
    .pc_incrementado_out(pc_out2), .instruction_out(ins_out2), .occupancy(occ2), .flush_drops(drops2)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    in_valid = v;
    pc_in = pc;
    ins_in = ins;
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    drive(1'b1, 32'd100, 32'hDEADBEEF);
    cyc();
    cyc();
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_ins", 64'(ins_out), 64'h0);
    chk("rst_pc", 64'(pc_out), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_drops", 64'(drops), 64'd0);
    chk("rst_drops2", 64'(drops2), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'd4, 32'h8C100000);
    cyc();
    chk("str1_valid", 64'(out_valid), 64'd1);
    chk("str1_pc", 64'(pc_out), 64'd4);
    chk("str1_ins", 64'(ins_out), 64'h8C100000);
    chk("str1_occ", 64'(occ), 64'd1);
    drive(1'b1, 32'd8, 32'h20080001);
    cyc();
    chk("str2_pc", 64'(pc_out), 64'd8);
    chk("str2_ins", 64'(ins_out), 64'h20080001);
    chk("str2_occ", 64'(occ), 64'd1);
    drive(1'b1, 32'd12, 32'h00000000);
    cyc();
    chk("str3_pc", 64'(pc_out), 64'd12);
    chk("str3_valid", 64'(out_valid), 64'd1);
    chk("str3_occ", 64'(occ), 64'd1);
    drive(1'b0, 32'd0, 32'h0);
    cyc();
    chk("str_end_valid", 64'(out_valid), 64'd0);
    chk("str_end_pc", 64'(pc_out), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'd4, 32'hAAAA0004);
    cyc();
    chk("bp1_occ", 64'(occ), 64'd1);
    drive(1'b1, 32'd8, 32'hAAAA0008);
    cyc();
    chk("bp2_occ", 64'(occ), 64'd2);
    chk("bp2_in_ready", 64'(in_ready), 64'd0);
    chk("bp2_head_pc", 64'(pc_out), 64'd4);
    chk("bp2_head_ins", 64'(ins_out), 64'hAAAA0004);
    drive(1'b0, 32'd0, 32'h0);
    out_ready = 1'b1;
    cyc();
    chk("bp3_pc", 64'(pc_out), 64'd8);
    chk("bp3_ins", 64'(ins_out), 64'hAAAA0008);
    chk("bp3_occ", 64'(occ), 64'd1);
    chk("bp3_in_ready", 64'(in_ready), 64'd1);
    cyc();
    chk("bp4_occ", 64'(occ), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'd4, 32'hBBBB0004);
    cyc();
    drive(1'b1, 32'd8, 32'hBBBB0008);
    cyc();
    chk("fl1_pre_occ", 64'(occ), 64'd2);
    drive(1'b1, 32'd12, 32'hBBBB000C);
    flush = 1'b1;
    cyc();
    chk("fl1_occ", 64'(occ), 64'd0);
    chk("fl1_drops", 64'(drops), 64'd2);
    chk("fl1_ins", 64'(ins_out), 64'h0);
    chk("fl1_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    drive(1'b1, 32'd16, 32'hCCCC0010);
    cyc();
    chk("fl2_pre_occ", 64'(occ), 64'd1);
    drive(1'b1, 32'd20, 32'hCCCC0014);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl2_pop_pc", 64'(pc_out), 64'd16);
    cyc();
    chk("fl2_drops", 64'(drops), 64'd3);
    chk("fl2_occ", 64'(occ), 64'd0);
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'd4, 32'hDDDD0004);
    cyc();
    chk("pp_pre_pc", 64'(pc_out), 64'd4);
    drive(1'b1, 32'd8, 32'hDDDD0008);
    out_ready = 1'b1;
    cyc();
    chk("pp_pc", 64'(pc_out), 64'd8);
    chk("pp_ins", 64'(ins_out), 64'hDDDD0008);
    chk("pp_occ", 64'(occ), 64'd1);
    drive(1'b0, 32'd0, 32'h0);
    out_ready = 1'b0;
    cyc();
    chk("stall_pc", 64'(pc_out), 64'd8);
    chk("stall_valid", 64'(out_valid), 64'd1);
    pc_in = 32'd4;
    ins_in = 32'hEEEE0004;
    in_valid2 = 1'b1;
    cyc();
    in_valid2 = 1'b0;
    flush2 = 1'b1;
    cyc();
    chk("sat1_drops", 64'(drops2), 64'd1);
    flush2 = 1'b0;
    in_valid2 = 1'b1;
    cyc();
    cyc();
    chk("sat2_pre_occ", 64'(occ2), 64'd2);
    in_valid2 = 1'b0;
    flush2 = 1'b1;
    cyc();
    chk("sat2_drops", 64'(drops2), 64'd3);
    flush2 = 1'b0;
    in_valid2 = 1'b1;
    cyc();
    cyc();
    in_valid2 = 1'b0;
    flush2 = 1'b1;
    cyc();
    chk("sat3_drops", 64'(drops2), 64'd3);
    chk("sat3_occ", 64'(occ2), 64'd0);
    flush2 = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
